// File: rtl/mcc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: FSM states, ALU codes,
// opcode/funct values and ALU B-input select encodings.
package mcc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_WB_R,
        S_WB_I,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_MEM_WB,
        S_BRANCH,
        S_HALT
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_LUI = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/multi_cycle_control_alu_decode.sv
// Combinational opcode/funct to ALU operation map, same encoding as the
// single-cycle controller; valid is low for anything unsupported.
module alu_decode
    import mcc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       valid
);

    always_comb begin
        alu_control = ALU_ADD;
        valid       = 1'b1;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  alu_control = ALU_ADD;
                FN_SUB:  alu_control = ALU_SUB;
                FN_AND:  alu_control = ALU_AND;
                FN_OR:   alu_control = ALU_OR;
                FN_XOR:  alu_control = ALU_XOR;
                FN_SLL:  alu_control = ALU_SLL;
                FN_SRL:  alu_control = ALU_SRL;
                FN_SRA:  alu_control = ALU_SRA;
                default: valid = 1'b0;
            endcase
        end else begin
            case (opcode)
                OP_ADDI, OP_LW, OP_SW: alu_control = ALU_ADD;
                OP_BEQ, OP_BNE:        alu_control = ALU_SUB;
                OP_ANDI:               alu_control = ALU_AND;
                OP_ORI:                alu_control = ALU_OR;
                OP_XORI:               alu_control = ALU_XOR;
                OP_LUI:                alu_control = ALU_LUI;
                default:               valid = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Moore FSM sequencing the multi-cycle MIPS datapath over a shared memory port
// with a ready handshake and a per-request timeout that parks the FSM in HALT.
module multi_cycle_control
    import mcc_pkg::*;
#(
    parameter int unsigned MEM_WAIT_LIMIT = 16,
    parameter int unsigned WAIT_CNT_W     = 5
) (
    input  logic       Clock,
    input  logic       ResetN,
    input  logic [5:0] OperationCode,
    input  logic [5:0] Function,
    input  logic       Zero,
    input  logic       MemoryReady,
    output logic       IorD,
    output logic       MemoryRead,
    output logic       MemoryWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCSource,
    output logic       ALUSourceA,
    output logic [1:0] ALUSourceB,
    output logic [3:0] ALUControl,
    output logic       RegisterDestination,
    output logic       MemoryToRegister,
    output logic       RegisterWrite,
    output logic       Retired,
    output logic       Illegal,
    output logic       Fault
);

    state_t                state, next_state;
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_next, cnt_inc;
    logic                  limit_hit;
    logic [3:0]            dec_alu;
    logic                  dec_valid;

    alu_decode u_alu_decode (
        .opcode      (OperationCode),
        .funct       (Function),
        .alu_control (dec_alu),
        .valid       (dec_valid)
    );

    assign cnt_inc   = wait_cnt + WAIT_CNT_W'(1);
    assign limit_hit = (cnt_inc == WAIT_CNT_W'(MEM_WAIT_LIMIT));

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        next_state          = state;
        wait_cnt_next       = '0;
        IorD                = 1'b0;
        MemoryRead          = 1'b0;
        MemoryWrite         = 1'b0;
        IRWrite             = 1'b0;
        PCWrite             = 1'b0;
        PCSource            = 1'b0;
        ALUSourceA          = 1'b0;
        ALUSourceB          = SRCB_REG;
        ALUControl          = ALU_ADD;
        RegisterDestination = 1'b0;
        MemoryToRegister    = 1'b0;
        RegisterWrite       = 1'b0;
        Retired             = 1'b0;
        Illegal             = 1'b0;
        Fault               = 1'b0;

        case (state)
            S_FETCH: begin
                MemoryRead = 1'b1;
                ALUSourceB = SRCB_FOUR;
                if (MemoryReady) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = S_DECODE;
                end else if (limit_hit) begin
                    next_state = S_HALT;
                end else begin
                    wait_cnt_next = cnt_inc;
                end
            end
            S_DECODE: begin
                ALUSourceB = SRCB_IMM_SH2;
                case (OperationCode)
                    OP_RTYPE:       next_state = S_EXEC_R;
                    OP_LW, OP_SW:   next_state = S_ADDR;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                                    next_state = S_EXEC_I;
                    default: begin
                        Illegal    = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                ALUSourceA = 1'b1;
                ALUSourceB = SRCB_REG;
                ALUControl = dec_valid ? dec_alu : ALU_ADD;
                if (dec_valid) begin
                    next_state = S_WB_R;
                end else begin
                    Illegal    = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXEC_I: begin
                ALUSourceA = 1'b1;
                ALUSourceB = SRCB_IMM;
                ALUControl = dec_alu;
                next_state = S_WB_I;
            end
            S_WB_R: begin
                RegisterWrite       = 1'b1;
                RegisterDestination = 1'b1;
                Retired             = 1'b1;
                next_state          = S_FETCH;
            end
            S_WB_I: begin
                RegisterWrite = 1'b1;
                Retired       = 1'b1;
                next_state    = S_FETCH;
            end
            S_ADDR: begin
                ALUSourceA = 1'b1;
                ALUSourceB = SRCB_IMM;
                next_state = (OperationCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                IorD       = 1'b1;
                MemoryRead = 1'b1;
                if (MemoryReady) begin
                    next_state = S_MEM_WB;
                end else if (limit_hit) begin
                    next_state = S_HALT;
                end else begin
                    wait_cnt_next = cnt_inc;
                end
            end
            S_MEM_WR: begin
                IorD        = 1'b1;
                MemoryWrite = 1'b1;
                if (MemoryReady) begin
                    Retired    = 1'b1;
                    next_state = S_FETCH;
                end else if (limit_hit) begin
                    next_state = S_HALT;
                end else begin
                    wait_cnt_next = cnt_inc;
                end
            end
            S_MEM_WB: begin
                RegisterWrite    = 1'b1;
                MemoryToRegister = 1'b1;
                Retired          = 1'b1;
                next_state       = S_FETCH;
            end
            S_BRANCH: begin
                ALUSourceA = 1'b1;
                ALUSourceB = SRCB_REG;
                ALUControl = ALU_SUB;
                PCSource   = 1'b1;
                PCWrite    = Zero ^ (OperationCode == OP_BNE);
                Retired    = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT: begin
                Fault = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase

        // Outputs are forced quiet while reset is held, so FETCH's read request
        // only appears once the controller is actually running.
        if (!ResetN) begin
            IorD                = 1'b0;
            MemoryRead          = 1'b0;
            MemoryWrite         = 1'b0;
            IRWrite             = 1'b0;
            PCWrite             = 1'b0;
            PCSource            = 1'b0;
            ALUSourceA          = 1'b0;
            ALUSourceB          = SRCB_REG;
            ALUControl          = ALU_ADD;
            RegisterDestination = 1'b0;
            MemoryToRegister    = 1'b0;
            RegisterWrite       = 1'b0;
            Retired             = 1'b0;
            Illegal             = 1'b0;
            Fault               = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: each step drives inputs mid-cycle and
// compares the full output vector against a hand-written per-state value.
module tb_multi_cycle_control;

    logic       Clock = 1'b0;
    logic       ResetN;
    logic [5:0] OperationCode;
    logic [5:0] Function;
    logic       Zero;
    logic       MemoryReady;
    logic       IorD, MemoryRead, MemoryWrite, IRWrite, PCWrite, PCSource;
    logic       ALUSourceA;
    logic [1:0] ALUSourceB;
    logic [3:0] ALUControl;
    logic       RegisterDestination, MemoryToRegister, RegisterWrite;
    logic       Retired, Illegal, Fault;

    int n_checks = 0;
    int n_fail   = 0;

    multi_cycle_control #(.MEM_WAIT_LIMIT(16), .WAIT_CNT_W(5)) dut (
        .Clock               (Clock),
        .ResetN              (ResetN),
        .OperationCode       (OperationCode),
        .Function            (Function),
        .Zero                (Zero),
        .MemoryReady         (MemoryReady),
        .IorD                (IorD),
        .MemoryRead          (MemoryRead),
        .MemoryWrite         (MemoryWrite),
        .IRWrite             (IRWrite),
        .PCWrite             (PCWrite),
        .PCSource            (PCSource),
        .ALUSourceA          (ALUSourceA),
        .ALUSourceB          (ALUSourceB),
        .ALUControl          (ALUControl),
        .RegisterDestination (RegisterDestination),
        .MemoryToRegister    (MemoryToRegister),
        .RegisterWrite       (RegisterWrite),
        .Retired             (Retired),
        .Illegal             (Illegal),
        .Fault               (Fault)
    );

    always #5 Clock = ~Clock;

    // {IorD,MRd,MWr,IRW,PCW,PCSrc,SrcA,SrcB[2],ALU[4],RegDst,MemToReg,RegW,Ret,Ill,Fault}
    logic [18:0] outs;
    assign outs = {IorD, MemoryRead, MemoryWrite, IRWrite, PCWrite, PCSource,
                   ALUSourceA, ALUSourceB, ALUControl, RegisterDestination,
                   MemoryToRegister, RegisterWrite, Retired, Illegal, Fault};

    localparam logic [18:0] V_ZERO     = 19'b0_0_0_0_0_0_0_00_0000_0_0_0_0_0_0;
    localparam logic [18:0] V_FETCH_W  = 19'b0_1_0_0_0_0_0_01_0000_0_0_0_0_0_0;
    localparam logic [18:0] V_FETCH_R  = 19'b0_1_0_1_1_0_0_01_0000_0_0_0_0_0_0;
    localparam logic [18:0] V_DECODE   = 19'b0_0_0_0_0_0_0_11_0000_0_0_0_0_0_0;
    localparam logic [18:0] V_DEC_ILL  = 19'b0_0_0_0_0_0_0_11_0000_0_0_0_0_1_0;
    localparam logic [18:0] V_EXR_ADD  = 19'b0_0_0_0_0_0_1_00_0000_0_0_0_0_0_0;
    localparam logic [18:0] V_EXR_SRA  = 19'b0_0_0_0_0_0_1_00_1000_0_0_0_0_0_0;
    localparam logic [18:0] V_EXR_ILL  = 19'b0_0_0_0_0_0_1_00_0000_0_0_0_0_1_0;
    localparam logic [18:0] V_EXI_LUI  = 19'b0_0_0_0_0_0_1_10_0111_0_0_0_0_0_0;
    localparam logic [18:0] V_WB_R     = 19'b0_0_0_0_0_0_0_00_0000_1_0_1_1_0_0;
    localparam logic [18:0] V_WB_I     = 19'b0_0_0_0_0_0_0_00_0000_0_0_1_1_0_0;
    localparam logic [18:0] V_ADDR     = 19'b0_0_0_0_0_0_1_10_0000_0_0_0_0_0_0;
    localparam logic [18:0] V_MEM_RD   = 19'b1_1_0_0_0_0_0_00_0000_0_0_0_0_0_0;
    localparam logic [18:0] V_MEM_WB   = 19'b0_0_0_0_0_0_0_00_0000_0_1_1_1_0_0;
    localparam logic [18:0] V_MEM_WR_W = 19'b1_0_1_0_0_0_0_00_0000_0_0_0_0_0_0;
    localparam logic [18:0] V_MEM_WR_R = 19'b1_0_1_0_0_0_0_00_0000_0_0_0_1_0_0;
    localparam logic [18:0] V_BR_TAKE  = 19'b0_0_0_0_1_1_1_00_0001_0_0_0_1_0_0;
    localparam logic [18:0] V_BR_NOT   = 19'b0_0_0_0_0_1_1_00_0001_0_0_0_1_0_0;
    localparam logic [18:0] V_HALT     = 19'b0_0_0_0_0_0_0_00_0000_0_0_0_0_0_1;

    task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic step(input logic rdy, input logic z, input logic [18:0] exp, input string tag);
        MemoryReady = rdy;
        Zero        = z;
        #1;
        chk(tag, outs, exp);
        tick();
    endtask

    initial begin
        ResetN        = 1'b0;
        OperationCode = 6'b000000;
        Function      = 6'b100000;
        Zero          = 1'b0;
        MemoryReady   = 1'b0;
        tick();
        tick();
        MemoryReady = 1'b1;
        #1;
        chk("reset_outputs", outs, V_ZERO);
        ResetN = 1'b1;

        // ADD: 4 cycles with ready on first fetch cycle
        step(1'b1, 1'b0, V_FETCH_R, "add_fetch");
        step(1'b1, 1'b0, V_DECODE,  "add_decode");
        step(1'b1, 1'b0, V_EXR_ADD, "add_exec");
        step(1'b1, 1'b0, V_WB_R,    "add_wb");

        // LW with two wait cycles in FETCH and in MEM_RD: 9 cycles
        OperationCode = 6'b100011;
        step(1'b0, 1'b0, V_FETCH_W, "lw_fetch_wait1");
        step(1'b0, 1'b0, V_FETCH_W, "lw_fetch_wait2");
        step(1'b1, 1'b0, V_FETCH_R, "lw_fetch_ready");
        step(1'b0, 1'b0, V_DECODE,  "lw_decode");
        step(1'b0, 1'b0, V_ADDR,    "lw_addr");
        step(1'b0, 1'b0, V_MEM_RD,  "lw_memrd_wait1");
        step(1'b0, 1'b0, V_MEM_RD,  "lw_memrd_wait2");
        step(1'b1, 1'b0, V_MEM_RD,  "lw_memrd_ready");
        step(1'b0, 1'b0, V_MEM_WB,  "lw_memwb");

        // BEQ taken, BNE not taken, BNE taken
        OperationCode = 6'b000100;
        step(1'b1, 1'b1, V_FETCH_R, "beq_fetch");
        step(1'b1, 1'b1, V_DECODE,  "beq_decode");
        step(1'b1, 1'b1, V_BR_TAKE, "beq_zero1");
        OperationCode = 6'b000101;
        step(1'b1, 1'b1, V_FETCH_R, "bne_fetch");
        step(1'b1, 1'b1, V_DECODE,  "bne_decode");
        step(1'b1, 1'b1, V_BR_NOT,  "bne_zero1");
        step(1'b1, 1'b0, V_FETCH_R, "bne2_fetch");
        step(1'b1, 1'b0, V_DECODE,  "bne2_decode");
        step(1'b1, 1'b0, V_BR_TAKE, "bne_zero0");

        // Illegal opcode then illegal funct
        OperationCode = 6'b111111;
        step(1'b1, 1'b0, V_FETCH_R, "illop_fetch");
        step(1'b1, 1'b0, V_DEC_ILL, "illop_decode");
        OperationCode = 6'b000000;
        Function      = 6'b001000;
        step(1'b1, 1'b0, V_FETCH_R, "illfn_fetch");
        step(1'b1, 1'b0, V_DECODE,  "illfn_decode");
        step(1'b1, 1'b0, V_EXR_ILL, "illfn_exec");

        // SRA and LUI decode through the shared ALU map
        Function = 6'b000011;
        step(1'b1, 1'b0, V_FETCH_R, "sra_fetch");
        step(1'b1, 1'b0, V_DECODE,  "sra_decode");
        step(1'b1, 1'b0, V_EXR_SRA, "sra_exec");
        step(1'b1, 1'b0, V_WB_R,    "sra_wb");
        OperationCode = 6'b001111;
        step(1'b1, 1'b0, V_FETCH_R, "lui_fetch");
        step(1'b1, 1'b0, V_DECODE,  "lui_decode");
        step(1'b1, 1'b0, V_EXI_LUI, "lui_exec");
        step(1'b1, 1'b0, V_WB_I,    "lui_wb");

        // SW answered in the limit cycle itself: 15 waits, ready on the 16th
        OperationCode = 6'b101011;
        step(1'b1, 1'b0, V_FETCH_R, "sw_lim_fetch");
        step(1'b1, 1'b0, V_DECODE,  "sw_lim_decode");
        step(1'b1, 1'b0, V_ADDR,    "sw_lim_addr");
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, V_MEM_WR_W, "sw_lim_wait");
        step(1'b1, 1'b0, V_MEM_WR_R, "sw_lim_ready");
        step(1'b0, 1'b0, V_FETCH_W,  "sw_lim_next_fetch");
        step(1'b1, 1'b0, V_FETCH_R,  "sw_to_fetch");

        // SW stuck: 16 unanswered cycles then HALT
        step(1'b1, 1'b0, V_DECODE,  "sw_to_decode");
        step(1'b1, 1'b0, V_ADDR,    "sw_to_addr");
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, V_MEM_WR_W, "sw_to_wait");
        step(1'b0, 1'b0, V_HALT, "halt_1");
        step(1'b1, 1'b0, V_HALT, "halt_ready_ignored");
        ResetN = 1'b0;
        #1;
        chk("halt_in_reset", outs, V_ZERO);
        tick();
        ResetN = 1'b1;
        step(1'b0, 1'b0, V_FETCH_W, "halt_reset_fetch");

        // Reset in the middle of MEM_WR
        step(1'b1, 1'b0, V_FETCH_R,  "swr_fetch");
        step(1'b1, 1'b0, V_DECODE,   "swr_decode");
        step(1'b1, 1'b0, V_ADDR,     "swr_addr");
        step(1'b0, 1'b0, V_MEM_WR_W, "swr_memwr");
        ResetN = 1'b0;
        tick();
        ResetN = 1'b1;
        step(1'b0, 1'b0, V_FETCH_W, "swr_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
Moore-style FSM sequencing the multi-cycle MIPS datapath: one shared memory port (instruction and data), one ALU, and IR, ALUOut and MDR registers. It decodes the same ISA subset as the single-cycle controller: R-type ADD/SUB/AND/OR/XOR/SLL/SRL/SRA, LW, SW, BEQ, BNE, ADDI, ANDI, ORI, XORI and LUI. It issues one memory request per access and waits on a ready handshake. It sits between the IR opcode/funct fields, the ALU Zero flag, and all datapath mux selects and write enables.

Parameters:
MEM_WAIT_LIMIT, 16, maximum number of cycles a memory request may stay unanswered before a fault (must be at least 1).
WAIT_CNT_W, 5, width of the wait counter; must satisfy 2^WAIT_CNT_W > MEM_WAIT_LIMIT.

Ports:
Clock  in  1  rising-edge clock.
ResetN  in  1  synchronous, active-low reset.
OperationCode  in  6  IR[31:26]; stable from DECODE until the next FETCH.
Function  in  6  IR[5:0].
Zero  in  1  combinational ALU zero flag for the current cycle.
MemoryReady  in  1  memory has completed the current read or write this cycle.
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
MemoryRead  out  1  read request.
MemoryWrite  out  1  write request.
IRWrite  out  1  load IR from memory read data.
PCWrite  out  1  load PC.
PCSource  out  1  PC input select: 0 = ALU result, 1 = ALUOut.
ALUSourceA  out  1  ALU A input: 0 = PC, 1 = register A.
ALUSourceB  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
ALUControl  out  4  ALU operation code.
RegisterDestination  out  1  destination register: 1 = rd, 0 = rt.
MemoryToRegister  out  1  write-back data: 1 = MDR, 0 = ALUOut.
RegisterWrite  out  1  register file write enable.
Retired  out  1  one-cycle pulse when an instruction completes.
Illegal  out  1  one-cycle pulse when an unsupported opcode/funct is decoded.
Fault  out  1  sticky; set on memory timeout.

Behaviour:
- All outputs are decoded only from the state register (plus Zero and MemoryReady where stated below).
- Reset (ResetN=0 at a clock edge) forces FETCH, clears the wait counter and clears Fault, including mid-instruction or mid-wait.
- Reset output values: every strobe is 0; all selects and ALUControl are 0.
- Default value of every output in every state is 0 unless listed.
- ALUControl encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, LUI 0111, SRA 1000.
- States and outputs:
  - FETCH: IorD=0, MemoryRead=1, ALUSourceB=01, ALU does ADD. When MemoryReady=1: IRWrite=1, PCWrite=1, PCSource=0, then go to DECODE. Otherwise stay in FETCH.
  - DECODE: ALUSourceA=0, ALUSourceB=11, ADD (branch target into ALUOut). Next state by opcode: R-type to EXEC_R; LW or SW to ADDR; BEQ or BNE to BRANCH; ADDI, ANDI, ORI, XORI or LUI to EXEC_I; anything else to FETCH with Illegal=1.
  - EXEC_R: ALUSourceA=1, ALUSourceB=00, ALUControl from Function; go to WB_R. An unsupported funct pulses Illegal and goes to FETCH with no register write.
  - EXEC_I: ALUSourceA=1, ALUSourceB=10, ALUControl from opcode; go to WB_I.
  - WB_R: RegisterWrite=1, RegisterDestination=1, MemoryToRegister=0, Retired=1; go to FETCH.
  - WB_I: RegisterWrite=1, RegisterDestination=0, MemoryToRegister=0, Retired=1; go to FETCH.
  - ADDR: ALUSourceA=1, ALUSourceB=10, ADD; go to MEM_RD (LW) or MEM_WR (SW).
  - MEM_RD: IorD=1, MemoryRead=1 until MemoryReady, then go to MEM_WB.
  - MEM_WR: IorD=1, MemoryWrite=1 until MemoryReady; on ready, Retired=1 and go to FETCH.
  - MEM_WB: RegisterWrite=1, RegisterDestination=0, MemoryToRegister=1, Retired=1; go to FETCH.
  - BRANCH: ALUSourceA=1, ALUSourceB=00, SUB, PCSource=1. PCWrite = Zero XOR (opcode is BNE). Retired=1; go to FETCH.
  - HALT: all strobes 0, Fault=1; left only by reset.
- Latency with MemoryReady=1 on the first request cycle: BEQ/BNE 3 cycles; R-type, I-type and SW 4 cycles; LW 5 cycles. Each extra wait cycle adds 1.
- Handshake rules:
  - Request signals stay asserted and constant until MemoryReady=1.
  - MemoryReady is ignored in every state other than FETCH, MEM_RD and MEM_WR.
  - MemoryRead and MemoryWrite are never both 1.
- Timeout:
  - The wait counter clears on entry to any memory state and increments on each cycle that state is held without ready.
  - When the counter reaches MEM_WAIT_LIMIT with MemoryReady still 0, go to HALT and set Fault.
  - MemoryReady=1 in the limit cycle itself counts as success.

Decomposition:
- Shared package mcc_pkg holds:
  - the state enum;
  - the ALUControl codes;
  - the opcode and funct constants;
  - the ALUSourceB select encodings.
- One combinational sub-module, alu_decode, maps opcode/funct to ALUControl plus a valid flag; it is shared with the single-cycle controller's encoding.

Test Plan:
- ADD R-type (opcode 000000, funct 100000), MemoryReady held at 1 → states FETCH, DECODE, EXEC_R, WB_R; RegisterWrite=1 with RegisterDestination=1 in cycle 4; Retired pulses once.
- LW (100011) with MemoryReady delayed 2 cycles in both FETCH and MEM_RD → 9 cycles total; MemoryRead held steady through the waits; IorD=1 only in MEM_RD.
- BEQ (000100) with Zero=1, then BNE (000101) with Zero=1 → PCWrite=1 with PCSource=1 for BEQ; PCWrite=0 for BNE; 3 cycles each.
- Opcode 111111, then R-type funct 001000 → Illegal pulses once for each; no RegisterWrite or MemoryWrite; next cycle is FETCH.
- SW with MemoryReady stuck at 0 and MEM_WAIT_LIMIT=16 → HALT entered after 16 wait cycles; Fault=1 and all strobes 0; ResetN=0 for one edge returns to FETCH with Fault=0.
- ResetN asserted during MEM_WR → next state FETCH; MemoryWrite=0 on the cycle after the reset edge.
